// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-port memory arbiter.
`timescale 1ns/1ps
package mem_arb_pkg;

  localparam int AW       = 16;
  localparam int DW       = 16;
  localparam int STARVE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2,
    OWN_X    = 2'd3
  } owner_e;

  // Command captured from the winning requester and held on mem_* outputs
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: d > if > x, unless x has been starved.
`timescale 1ns/1ps
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_req_i,
  input  logic       d_req_i,
  input  logic       x_req_i,
  input  logic       starve_i,
  output logic [1:0] owner_o
);

  // A starved external request overrides the fixed priority order
  always_comb begin
    owner_o = OWN_NONE;
    if (x_req_i && starve_i) owner_o = OWN_X;
    else if (d_req_i)        owner_o = OWN_D;
    else if (if_req_i)       owner_o = OWN_IF;
    else if (x_req_i)        owner_o = OWN_X;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester memory arbiter: IDLE grants, WAIT for mem_ready or
// timeout, DONE pulses the owner's ack with the captured read data.
`timescale 1ns/1ps
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  input  logic          x_req,
  input  logic          x_we,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_wdata,
  output logic          x_ack,
  output logic [DW-1:0] rd_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          mem_force,
  output logic          timeout_err
);

  // WAIT counter runs 0..TIMEOUT-1; the last value is the final WAIT cycle
  localparam int                  TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]       WAIT_LAST  = TW'(TIMEOUT - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  mem_cmd_t            sel_cmd, cmd_q, cmd_d;
  logic                mem_req_q, mem_req_d;
  logic [DW-1:0]       rd_data_q, rd_data_d;
  logic                terr_q, terr_d;
  logic [TW-1:0]       wcnt_q, wcnt_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [1:0]          pick;
  logic                starved;
  logic                any_req;

  assign any_req = if_req | d_req | x_req;
  assign starved = (starve_q == STARVE_MAX);

  mem_arb_pick u_pick (
    .if_req_i (if_req),
    .d_req_i  (d_req),
    .x_req_i  (x_req),
    .starve_i (starved),
    .owner_o  (pick)
  );

  // Command of the current winner; fetches are always reads with no data
  always_comb begin
    sel_cmd = '0;
    case (pick)
      OWN_IF: begin
        sel_cmd.addr = if_addr;
      end
      OWN_D: begin
        sel_cmd.we    = d_we;
        sel_cmd.addr  = d_addr;
        sel_cmd.wdata = d_wdata;
      end
      OWN_X: begin
        sel_cmd.we    = x_we;
        sel_cmd.addr  = x_addr;
        sel_cmd.wdata = x_wdata;
      end
      default: sel_cmd = '0;
    endcase
  end

  // Access sequencer: grant in IDLE, wait for completion or abort, ack in DONE.
  // mem_ready is tested before the timeout so a last-cycle completion wins.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cmd_d     = cmd_q;
    mem_req_d = mem_req_q;
    rd_data_d = rd_data_q;
    terr_d    = terr_q;
    wcnt_d    = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d   = ST_WAIT;
          owner_d   = owner_e'(pick);
          cmd_d     = sel_cmd;
          mem_req_d = 1'b1;
          wcnt_d    = '0;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          cmd_d.we  = 1'b0;
          rd_data_d = cmd_q.we ? '0 : mem_rdata;
        end else if (wcnt_q == WAIT_LAST) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          cmd_d.we  = 1'b0;
          rd_data_d = '0;
          terr_d    = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d   = ST_IDLE;
        owner_d   = OWN_NONE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Starvation tracking: count grants lost by a waiting x, saturating
  always_comb begin
    starve_d = starve_q;
    if (!x_req) begin
      starve_d = '0;
    end else if (state_q == ST_IDLE) begin
      if (pick == OWN_X)  starve_d = '0;
      else if (!starved)  starve_d = starve_q + 1'b1;
    end
  end

  // State register; reset drops any access in flight without an ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_NONE;
      cmd_q     <= '0;
      mem_req_q <= 1'b0;
      rd_data_q <= '0;
      terr_q    <= 1'b0;
      wcnt_q    <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cmd_q     <= cmd_d;
      mem_req_q <= mem_req_d;
      rd_data_q <= rd_data_d;
      terr_q    <= terr_d;
      wcnt_q    <= wcnt_d;
      starve_q  <= starve_d;
    end
  end

  // Acks decode from registered state, so at most one is ever high
  assign if_ack      = (state_q == ST_DONE) && (owner_q == OWN_IF);
  assign d_ack       = (state_q == ST_DONE) && (owner_q == OWN_D);
  assign x_ack       = (state_q == ST_DONE) && (owner_q == OWN_X);
  assign rd_data     = rd_data_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = cmd_q.we;
  assign mem_addr    = cmd_q.addr;
  assign mem_wdata   = cmd_q.wdata;
  assign mem_force   = d_req & ~d_ack;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// rounds checked against a transaction-level schedule model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int          SLIM = 4;
  localparam int          TMO  = 15;
  localparam logic [15:0] KEY  = 16'hBEAF;   // memory returns addr ^ KEY

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  logic        clk = 1'b0, reset = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, x_req = 1'b0, x_we = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0, x_addr = '0, x_wdata = '0;
  logic        if_ack, d_ack, x_ack, mem_req, mem_we, mem_force, timeout_err;
  logic [15:0] rd_data, mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready = 1'b0;
  logic [2:0]  acks;

  int checks = 0, errors = 0;
  int dly_q[$];
  int rsp_cnt = 0, rsp_dly = 0;
  int m_starve = 0;
  bit m_err = 1'b0;

  mem_arbiter #(.STARVE_LIM(SLIM), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata), .x_ack(x_ack),
    .rd_data(rd_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_force(mem_force), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem_addr ^ KEY;
  assign acks = {x_ack, d_ack, if_ack};

  // Memory model: each access takes its latency from dly_q in grant order
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      mem_ready = 1'b0; rsp_cnt = 0;
    end else if (mem_req) begin
      if (rsp_cnt == 0) rsp_dly = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
      mem_ready = (rsp_cnt == rsp_dly);
      rsp_cnt++;
    end else begin
      mem_ready = 1'b0; rsp_cnt = 0;
    end
  end

  task automatic test_reset();
    @(posedge clk); #1;
    checks++; if (acks !== 3'b000) begin errors++; $display("FAIL reset_acks: got %b want 000", acks); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
    checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0000", mem_wdata); end
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_dual();
    logic [2:0] ev;
    dly_q = '{0, 0};
    d_req = 1; d_we = 0; d_addr = 16'h0010; if_req = 1; if_addr = 16'h0020;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      ev = (c == 3) ? 3'b010 : (c == 6) ? 3'b001 : 3'b000;
      checks++; if (acks !== ev) begin errors++; $display("FAIL dual_acks c%0d: got %b want %b", c, acks, ev); end
      if (c == 2 || c == 5) begin
        checks++;
        if (mem_addr !== ((c == 2) ? 16'h0010 : 16'h0020)) begin errors++; $display("FAIL dual_addr c%0d: got %h", c, mem_addr); end
      end
      if (c == 3 || c == 6) begin
        checks++;
        if (rd_data !== (((c == 3) ? 16'h0010 : 16'h0020) ^ KEY)) begin errors++; $display("FAIL dual_rdata c%0d: got %h", c, rd_data); end
      end
      @(posedge clk); #1;
      if (c == 3) d_req = 0;
      if (c == 6) if_req = 0;
    end
  endtask

  task automatic test_delayed_read();
    int fcnt = 0;
    dly_q = '{3};
    d_req = 1; d_we = 0; d_addr = 16'h0040;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (mem_force) fcnt++;
      checks++; if (mem_force !== (c <= 5)) begin errors++; $display("FAIL dly_force c%0d: got %b", c, mem_force); end
      checks++; if (d_ack !== (c == 6)) begin errors++; $display("FAIL dly_dack c%0d: got %b", c, d_ack); end
      if (c == 6) begin
        checks++; if (rd_data !== 16'hBEEF) begin errors++; $display("FAIL dly_rdata: got %h want beef", rd_data); end
      end
      @(posedge clk); #1;
      if (c == 6) d_req = 0;
    end
    checks++; if (fcnt != 5) begin errors++; $display("FAIL dly_force_len: got %0d want 5", fcnt); end
  endtask

  task automatic test_starve();
    logic [2:0] ev;
    dly_q = '{0, 0, 0, 0, 0};
    x_req = 1; x_we = 0; x_addr = 16'h0300;
    d_req = 1; d_we = 0; d_addr = 16'h0100;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      ev = (c == 15) ? 3'b100 : (c % 3 == 0) ? 3'b010 : 3'b000;
      checks++; if (acks !== ev) begin errors++; $display("FAIL starve_acks c%0d: got %b want %b", c, acks, ev); end
      if (c == 14) begin
        checks++; if (mem_addr !== 16'h0300) begin errors++; $display("FAIL starve_xaddr: got %h want 0300", mem_addr); end
      end
      @(posedge clk); #1;
      if (c % 3 == 0) d_addr = d_addr + 16'h1;
      if (c == 15) begin x_req = 0; d_req = 0; end
    end
  endtask

  task automatic test_drop_in_wait();
    dly_q = '{2};
    x_req = 1; x_we = 1; x_addr = 16'h0055; x_wdata = 16'h1234;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h0055, 16'h1234}) begin
          errors++; $display("FAIL drop_cmd: got %b %b %h %h", mem_req, mem_we, mem_addr, mem_wdata);
        end
      end
      checks++; if (acks !== ((c == 5) ? 3'b100 : 3'b000)) begin errors++; $display("FAIL drop_acks c%0d: got %b", c, acks); end
      if (c == 5) begin
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL drop_wr_rdata: got %h want 0000", rd_data); end
      end
      @(posedge clk); #1;
      if (c == 2) x_req = 0;
    end
    x_we = 0;
  endtask

  task automatic test_ready_at_limit();
    dly_q = '{TMO - 1};
    if_req = 1; if_addr = 16'h0123;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      checks++; if (if_ack !== (c == 17)) begin errors++; $display("FAIL limit_ack c%0d: got %b", c, if_ack); end
      if (c == 17) begin
        checks++; if (rd_data !== (16'h0123 ^ KEY)) begin errors++; $display("FAIL limit_rdata: got %h", rd_data); end
      end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL limit_terr c%0d: got %b want 0", c, timeout_err); end
      @(posedge clk); #1;
      if (c == 17) if_req = 0;
    end
  endtask

  task automatic test_timeout();
    int mcnt = 0;
    dly_q = '{100};
    if_req = 1; if_addr = 16'h0077;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_req) mcnt++;
      checks++; if (if_ack !== (c == 17)) begin errors++; $display("FAIL tmo_ack c%0d: got %b", c, if_ack); end
      if (c == 17) begin
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL tmo_rdata: got %h want 0000", rd_data); end
      end
      checks++; if (timeout_err !== (c >= 17)) begin errors++; $display("FAIL tmo_terr c%0d: got %b", c, timeout_err); end
      @(posedge clk); #1;
      if (c == 17) if_req = 0;
    end
    checks++; if (mcnt != TMO) begin errors++; $display("FAIL tmo_wait_len: got %0d want %0d", mcnt, TMO); end
  endtask

  task automatic test_reset_mid_wait();
    dly_q = '{50};
    if_req = 1; if_addr = 16'h0ABC;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b want 1", mem_req); end
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_async_req: got %b want 0", mem_req); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_async_terr: got %b want 0", timeout_err); end
    checks++; if (acks !== 3'b000) begin errors++; $display("FAIL rst_async_acks: got %b", acks); end
    if_req = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    dly_q.delete();
    @(negedge clk);
    checks++; if (acks !== 3'b000) begin errors++; $display("FAIL rst_post_acks: got %b", acks); end
    @(posedge clk); #1;
    dly_q = '{1};
    if_req = 1; if_addr = 16'h0BCD;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++; if (if_ack !== (c == 4)) begin errors++; $display("FAIL rst_new_ack c%0d: got %b", c, if_ack); end
      if (c == 4) begin
        checks++; if (rd_data !== (16'h0BCD ^ KEY)) begin errors++; $display("FAIL rst_new_rdata: got %h", rd_data); end
      end
      @(posedge clk); #1;
      if (c == 4) if_req = 0;
    end
  endtask

  // One random round: every requester gets a short burst of transactions;
  // the model predicts grant order and each ack cycle from the rules.
  task automatic test_random_round();
    txn_t ti[$], td[$], tx[$], mi[$], md[$], mx[$], tr;
    int e_ack[$], e_w1[$];
    logic [2:0] e_vec[$], ev, got;
    logic [15:0] e_rd[$];
    txn_t e_tx[$];
    int ni, nd, nx, t, who, dly, wt, ai, gi;
    bit xp, to;
    ni = $urandom_range(0, 3); nd = $urandom_range(0, 3); nx = $urandom_range(0, 2);
    if (ni + nd + nx == 0) ni = 1;
    for (int k = 0; k < ni; k++) begin tr = '0; tr.addr = 16'($urandom); ti.push_back(tr); end
    for (int k = 0; k < nd; k++) begin tr.we = 1'($urandom); tr.addr = 16'($urandom); tr.wdata = 16'($urandom); td.push_back(tr); end
    for (int k = 0; k < nx; k++) begin tr.we = 1'($urandom); tr.addr = 16'($urandom); tr.wdata = 16'($urandom); tx.push_back(tr); end
    mi = ti; md = td; mx = tx;
    t = 1;
    while (mi.size() + md.size() + mx.size() > 0) begin
      xp = (mx.size() > 0);
      if (m_starve == SLIM && xp) who = 3;
      else if (md.size() > 0)     who = 2;
      else if (mi.size() > 0)     who = 1;
      else                        who = 3;
      m_starve = (who == 3 || !xp) ? 0 : ((m_starve < SLIM) ? m_starve + 1 : SLIM);
      if (who == 1) tr = mi.pop_front(); else if (who == 2) tr = md.pop_front(); else tr = mx.pop_front();
      dly = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 4);
      dly_q.push_back(dly);
      to = (dly >= TMO);
      wt = to ? TMO : dly + 1;
      if (to) m_err = 1'b1;
      e_w1.push_back(t + 1);
      e_ack.push_back(t + 1 + wt);
      e_vec.push_back((who == 1) ? 3'b001 : (who == 2) ? 3'b010 : 3'b100);
      e_rd.push_back((tr.we || to) ? 16'h0 : (tr.addr ^ KEY));
      e_tx.push_back(tr);
      t = t + wt + 2;
    end
    m_starve = 0;
    if (ti.size() > 0) begin if_req = 1; if_addr = ti[0].addr; end
    if (td.size() > 0) begin d_req = 1; d_we = td[0].we; d_addr = td[0].addr; d_wdata = td[0].wdata; end
    if (tx.size() > 0) begin x_req = 1; x_we = tx[0].we; x_addr = tx[0].addr; x_wdata = tx[0].wdata; end
    ai = 0; gi = 0;
    for (int c = 1; c <= t + 2; c++) begin
      @(negedge clk);
      ev = (ai < e_ack.size() && e_ack[ai] == c) ? e_vec[ai] : 3'b000;
      got = acks;
      checks++; if (got !== ev) begin errors++; $display("FAIL rnd_acks c%0d: got %b want %b", c, got, ev); end
      if (ev != 3'b000) begin
        checks++; if (rd_data !== e_rd[ai]) begin errors++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, rd_data, e_rd[ai]); end
        ai++;
      end
      if (gi < e_w1.size() && e_w1[gi] == c) begin
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, e_tx[gi]}) begin
          errors++; $display("FAIL rnd_cmd c%0d: got %b %b %h %h want %b %h %h", c, mem_req, mem_we, mem_addr, mem_wdata,
                             e_tx[gi].we, e_tx[gi].addr, e_tx[gi].wdata);
        end
        gi++;
      end
      @(posedge clk); #1;
      if (got[0] && ti.size() > 0) begin tr = ti.pop_front(); if (ti.size() > 0) if_addr = ti[0].addr; else if_req = 0; end
      if (got[1] && td.size() > 0) begin
        tr = td.pop_front();
        if (td.size() > 0) begin d_we = td[0].we; d_addr = td[0].addr; d_wdata = td[0].wdata; end else d_req = 0;
      end
      if (got[2] && tx.size() > 0) begin
        tr = tx.pop_front();
        if (tx.size() > 0) begin x_we = tx[0].we; x_addr = tx[0].addr; x_wdata = tx[0].wdata; end else x_req = 0;
      end
    end
    checks++;
    if (ti.size() + td.size() + tx.size() != 0) begin
      errors++; $display("FAIL rnd_unserved: got %0d pending want 0", ti.size() + td.size() + tx.size());
    end
    checks++; if (timeout_err !== m_err) begin errors++; $display("FAIL rnd_terr: got %b want %b", timeout_err, m_err); end
    if_req = 0; d_req = 0; x_req = 0;
    dly_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_dual();
    test_delayed_read();
    test_starve();
    test_drop_in_wait();
    test_ready_at_limit();
    test_timeout();
    test_reset_mid_wait();
    m_err = 1'b0;
    for (int r = 0; r < 40; r++) test_random_round();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
